// File: rtl/datapath.sv
// Single-bus 32-bit datapath for the teaching CPU: register file, special registers, ALU, CON, 512-word memory.
// Memory starts zeroed.
module datapath (
  input logic clk,
  input logic clr,
  input logic read,
  input logic write,
  input logic PCout,
  input logic Zlowout,
  input logic Zhighout,
  input logic MDRout,
  input logic Cout,
  input logic IN_Portout,
  input logic LOout,
  input logic HIout,
  input logic MARIn,
  input logic PCIn,
  input logic MDRIn,
  input logic IRIn,
  input logic YIn,
  input logic IncPC,
  input logic HiIn,
  input logic LoIn,
  input logic CIn,
  input logic InIn,
  input logic OutIn,
  input logic ZIn,
  input logic CONIn,
  input logic Gra,
  input logic Grb,
  input logic Grc,
  input logic RIn,
  input logic Rout,
  input logic BAout,
  input logic add,
  input logic subtract,
  input logic multiply,
  input logic divide
);
  localparam int DEPTH = 512;

  logic [31:0]       pc, ir, mar, mdr, y, hi, lo, in_port, out_port;
  logic [15:0][31:0] rf;
  logic [63:0]       z;
  logic              con;
  logic [31:0]       mem [DEPTH];

  logic [31:0]        bus, c_sext;
  logic [3:0]         sel;
  logic [63:0]        alu, div_res;
  logic signed [63:0] prod;
  logic signed [31:0] ys, bs;
  logic               cond;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  assign sel    = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign c_sext = {{13{ir[18]}}, ir[18:0]};

  always_comb begin
    bus = '0;
    if      (PCout)      bus = pc;
    else if (MDRout)     bus = mdr;
    else if (Zlowout)    bus = z[31:0];
    else if (Zhighout)   bus = z[63:32];
    else if (HIout)      bus = hi;
    else if (LOout)      bus = lo;
    else if (IN_Portout) bus = in_port;
    else if (Cout)       bus = c_sext;
    else if (Rout)       bus = rf[sel];
    else if (BAout)      bus = (sel == 4'd0) ? 32'h0 : rf[sel];
  end

  assign ys   = y;
  assign bs   = bus;
  assign prod = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});

  // Divide only when the divisor is nonzero; the one overflowing quotient wraps to itself.
  always_comb begin
    div_res = {y, 32'h0};
    if (bus != 32'h0) begin
      if (y == 32'h8000_0000 && bus == 32'hFFFF_FFFF) div_res = {32'h0, y};
      else div_res = {32'(ys % bs), 32'(ys / bs)};
    end
  end

  always_comb begin
    alu = {32'h0, bus};
    if      (IncPC)    alu = {32'h0, bus + 32'd1};
    else if (add)      alu = {32'h0, y + bus};
    else if (subtract) alu = {32'h0, y - bus};
    else if (multiply) alu = prod;
    else if (divide)   alu = div_res;
  end

  always_comb begin
    case (ir[20:19])
      2'b00:   cond = (bus == 32'h0);
      2'b01:   cond = (bus != 32'h0);
      2'b10:   cond = ~bus[31];
      default: cond = bus[31];
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc <= '0; ir <= '0; mar <= '0; mdr <= '0; y <= '0;
      hi <= '0; lo <= '0; in_port <= '0; out_port <= '0;
      rf <= '0; z <= '0; con <= 1'b0;
    end else begin
      if (MARIn) mar      <= bus;
      if (PCIn)  pc       <= bus;
      if (IRIn)  ir       <= bus;
      if (YIn)   y        <= bus;
      if (HiIn)  hi       <= bus;
      if (LoIn)  lo       <= bus;
      if (InIn)  in_port  <= bus;
      if (OutIn) out_port <= bus;
      if (MDRIn) mdr      <= read ? mem[mar[8:0]] : bus;
      if (RIn)   rf[sel]  <= bus;
      if (ZIn || IncPC) z <= alu;
      if (CONIn) con      <= cond;
    end
  end

  // Memory is outside the clr domain; a write samples the MDR value from before this edge.
  always_ff @(posedge clk) begin
    if (write) mem[mar[8:0]] <= mdr;
  end

  logic unused;
  assign unused = ^{CIn, ir[31:27], mar[31:9], out_port};
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: drives the control strobes as the sequencer would and
// checks internal state against a behavioural model.
module tb_datapath;
  logic clk = 1'b0, clr = 1'b0;
  logic read, write, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout;
  logic MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn;
  logic Gra, Grb, Grc, RIn, Rout, BAout, add, subtract, multiply, divide;

  int n_chk = 0, n_fail = 0;

  localparam int T_IR = 0, T_HI = 1, T_Y = 2, T_MAR = 3, T_MDR = 4, T_PC = 5;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .clr(clr), .read(read), .write(write), .PCout(PCout), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout), .IN_Portout(IN_Portout), .LOout(LOout),
    .HIout(HIout), .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn),
    .IncPC(IncPC), .HiIn(HiIn), .LoIn(LoIn), .CIn(CIn), .InIn(InIn), .OutIn(OutIn), .ZIn(ZIn),
    .CONIn(CONIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .Rout(Rout), .BAout(BAout),
    .add(add), .subtract(subtract), .multiply(multiply), .divide(divide)
  );

  task automatic clear_strobes();
    {read, write, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout} = '0;
    {MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn} = '0;
    {Gra, Grb, Grc, RIn, Rout, BAout, add, subtract, multiply, divide} = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    clear_strobes();
  endtask

  // The block has no data input, so constants are synthesised in Zlow by doubling and incrementing.
  task automatic build(input logic [31:0] v);
    ZIn = 1; step();
    for (int i = 31; i >= 0; i--) begin
      Zlowout = 1; YIn = 1; step();
      Zlowout = 1; add = 1; ZIn = 1; step();
      if (v[i]) begin Zlowout = 1; IncPC = 1; step(); end
    end
  endtask

  task automatic load(input logic [31:0] v, input int tgt);
    build(v);
    Zlowout = 1;
    case (tgt)
      T_IR:    IRIn = 1;
      T_HI:    HiIn = 1;
      T_Y:     YIn = 1;
      T_MAR:   MARIn = 1;
      T_MDR:   MDRIn = 1;
      default: PCIn = 1;
    endcase
    step();
  endtask

  // op: 0 IncPC, 1 add, 2 subtract, 3 multiply, 4 divide, 5 none
  function automatic logic [63:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      0: return {32'h0, b + 32'd1};
      1: return {32'h0, a + b};
      2: return {32'h0, a - b};
      3: return 64'(sa * sb);
      4: begin
        if (b == 32'h0) return {a, 32'h0};
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q = ma / mb;
        r = ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
      end
      default: return {32'h0, b};
    endcase
  endfunction

  task automatic set_op(input int op);
    case (op)
      0: IncPC = 1;
      1: add = 1;
      2: subtract = 1;
      3: multiply = 1;
      4: divide = 1;
      default: ;
    endcase
    if (op != 0) ZIn = 1;
  endtask

  task automatic run_alu(input int op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [63:0] exp;
    load(b, T_HI);
    load(a, T_Y);
    HIout = 1; set_op(op); step();
    exp = ref_alu(op, a, b);
    n_chk++;
    if (dut.z !== exp) begin
      n_fail++;
      $display("FAIL %s a=%h b=%h: z=%h expected %h", name, a, b, dut.z, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if ({dut.pc, dut.mar, dut.ir, dut.rf[5]} !== 128'h0 || dut.z !== 64'h0 || dut.con !== 1'b0) begin
      n_fail++; $display("FAIL reset_initial: pc=%h mar=%h ir=%h z=%h con=%b expected all 0",
                         dut.pc, dut.mar, dut.ir, dut.z, dut.con);
    end
    #10 clr = 0;
    load(32'h0280_001F, T_IR);
    load($urandom | 32'h1, T_PC);
    load(32'h0000_0123, T_MAR);
    Zlowout = 1; Gra = 1; RIn = 1; step();
    CONIn = 1; step();
    n_chk++; if (dut.rf[5] !== 32'h123 || dut.con !== 1'b1 || dut.pc == 32'h0) begin
      n_fail++; $display("FAIL reset_preload: r5=%h con=%b pc=%h expected 123,1,nonzero", dut.rf[5], dut.con, dut.pc);
    end
    #3 clr = 1;
    #1;
    n_chk++; if (dut.pc !== 32'h0 || dut.mar !== 32'h0 || dut.ir !== 32'h0) begin
      n_fail++; $display("FAIL reset_async_regs: pc=%h mar=%h ir=%h expected 0", dut.pc, dut.mar, dut.ir);
    end
    n_chk++; if (dut.z !== 64'h0 || dut.rf[5] !== 32'h0 || dut.con !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_zrc: z=%h r5=%h con=%b expected 0", dut.z, dut.rf[5], dut.con);
    end
    IncPC = 1; step();
    n_chk++; if (dut.z !== 64'h0) begin
      n_fail++; $display("FAIL reset_hold: z=%h expected 0", dut.z);
    end
    #3 clr = 0;
    IncPC = 1; step();
    n_chk++; if (dut.z !== 64'h1) begin
      n_fail++; $display("FAIL reset_release: z=%h expected 1", dut.z);
    end
  endtask

  task automatic test_fetch();
    load(32'hA280_0000, T_MDR);
    load(32'h0, T_MAR);
    write = 1; step();
    load(32'h0, T_PC);
    PCout = 1; MARIn = 1; IncPC = 1; step();
    n_chk++; if (dut.mar !== 32'h0 || dut.z[31:0] !== 32'h1) begin
      n_fail++; $display("FAIL fetch_t0: mar=%h zlow=%h expected 0,1", dut.mar, dut.z[31:0]);
    end
    load(32'hFFFF_FFFF, T_MDR);
    Zlowout = 1; build(32'h0); IncPC = 1; step();
    Zlowout = 1; PCIn = 1; MDRIn = 1; read = 1; step();
    n_chk++; if (dut.pc !== 32'h1 || dut.mdr !== 32'hA280_0000) begin
      n_fail++; $display("FAIL fetch_t1: pc=%h mdr=%h expected 1,a2800000", dut.pc, dut.mdr);
    end
    MDRout = 1; IRIn = 1; step();
    n_chk++; if (dut.ir !== 32'hA280_0000) begin
      n_fail++; $display("FAIL fetch_t2: ir=%h expected a2800000", dut.ir);
    end
  endtask

  task automatic test_cout_jr();
    load(32'h0280_001F, T_IR);
    Cout = 1; Gra = 1; RIn = 1; step();
    n_chk++; if (dut.rf[5] !== 32'h1F) begin
      n_fail++; $display("FAIL cout_r5: r5=%h expected 1f", dut.rf[5]);
    end
    load(32'hA280_0000, T_IR);
    Gra = 1; Rout = 1; PCIn = 1; step();
    n_chk++; if (dut.pc !== 32'h1F) begin
      n_fail++; $display("FAIL jr_pc: pc=%h expected 1f", dut.pc);
    end
    load(32'h0004_0000, T_IR);
    Cout = 1; ZIn = 1; step();
    n_chk++; if (dut.z !== 64'h0000_0000_FFFC_0000) begin
      n_fail++; $display("FAIL cout_sext: z=%h expected fffc0000", dut.z);
    end
  endtask

  task automatic test_alu_vectors();
    run_alu(3, 32'hFFFF_FFFD, 32'd7, "mul_neg3x7");
    run_alu(4, 32'd17, 32'd5, "div_17_5");
    run_alu(4, 32'd9, 32'd0, "div_by_zero");
    run_alu(4, 32'hFFFF_FFEF, 32'd5, "div_neg17_5");
    run_alu(5, 32'd3, 32'hDEAD_BEEF, "no_op_pass");
    load(32'd5, T_HI);
    load(32'd9, T_Y);
    HIout = 1; add = 1; subtract = 1; ZIn = 1; step();
    n_chk++; if (dut.z !== 64'd14) begin
      n_fail++; $display("FAIL prio_add_sub: z=%h expected e", dut.z);
    end
    HIout = 1; subtract = 1; multiply = 1; ZIn = 1; step();
    n_chk++; if (dut.z !== 64'd4) begin
      n_fail++; $display("FAIL prio_sub_mul: z=%h expected 4", dut.z);
    end
  endtask

  task automatic test_alu_random();
    logic [31:0] a, b;
    for (int op = 0; op < 5; op++) begin
      for (int k = 0; k < 5; k++) begin
        a = $urandom;
        b = (k == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        if (k == 1) a = -a >> 20;
        if (op == 4 && k == 2) b = 32'h0;
        if (op == 4 && k == 3) b = -32'($urandom_range(1, 9));
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
        run_alu(op, a, b, "alu_random");
      end
    end
  endtask

  task automatic test_memory();
    logic [31:0] mref [512];
    logic [31:0] addrs [$];
    logic [31:0] a, d, d2;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; d = $urandom;
      load(d, T_MDR);
      load(a, T_MAR);
      write = 1; step();
      mref[a[8:0]] = d;
      addrs.push_back(a);
    end
    foreach (addrs[k]) begin
      a = {addrs[k][31:9] ^ 23'h5A5, addrs[k][8:0]};
      load(a, T_MAR);
      MDRIn = 1; read = 1; step();
      n_chk++; if (dut.mdr !== mref[a[8:0]]) begin
        n_fail++; $display("FAIL mem_readback addr=%h: mdr=%h expected %h", a, dut.mdr, mref[a[8:0]]);
      end
    end
    d = $urandom; d2 = ~d; a = 32'h0000_0133;
    load(d, T_MDR);
    load(a, T_MAR);
    build(d2);
    Zlowout = 1; MDRIn = 1; write = 1; step();
    n_chk++; if (dut.mdr !== d2) begin
      n_fail++; $display("FAIL mem_wr_mdrin_mdr: mdr=%h expected %h", dut.mdr, d2);
    end
    MDRIn = 1; read = 1; step();
    n_chk++; if (dut.mdr !== d) begin
      n_fail++; $display("FAIL mem_wr_old_mdr: mdr=%h expected %h", dut.mdr, d);
    end
  endtask

  task automatic test_con_ba();
    logic [3:0] c2_exp;
    load(32'h0, T_IR);
    CONIn = 1; step();
    n_chk++; if (dut.con !== 1'b1) begin
      n_fail++; $display("FAIL con_c2_00: con=%b expected 1", dut.con);
    end
    load(32'h0008_0000, T_IR);
    CONIn = 1; step();
    n_chk++; if (dut.con !== 1'b0) begin
      n_fail++; $display("FAIL con_c2_01_zero: con=%b expected 0", dut.con);
    end
    load(32'h8000_0000, T_HI);
    load(32'h0018_0000, T_IR);
    HIout = 1; CONIn = 1; step();
    n_chk++; if (dut.con !== 1'b1) begin
      n_fail++; $display("FAIL con_c2_11: con=%b expected 1", dut.con);
    end
    load(32'h0010_0000, T_IR);
    HIout = 1; CONIn = 1; step();
    n_chk++; if (dut.con !== 1'b0) begin
      n_fail++; $display("FAIL con_c2_10: con=%b expected 0", dut.con);
    end
    load(32'h0, T_IR);
    build(32'h55);
    Zlowout = 1; Gra = 1; RIn = 1; step();
    BAout = 1; Gra = 1; #1;
    n_chk++; if (dut.bus !== 32'h0) begin
      n_fail++; $display("FAIL baout_r0: bus=%h expected 0", dut.bus);
    end
    Rout = 1; #1;
    n_chk++; if (dut.bus !== 32'h55) begin
      n_fail++; $display("FAIL rout_r0: bus=%h expected 55", dut.bus);
    end
    clear_strobes();
    HIout = 1; PCout = 1; #1;
    c2_exp = 4'h0;
    n_chk++; if (dut.bus !== dut.pc || dut.pc === 32'h8000_0000 || c2_exp !== 4'h0) begin
      n_fail++; $display("FAIL bus_prio_pc: bus=%h expected pc %h", dut.bus, dut.pc);
    end
    clear_strobes();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_strobes();
    #1 clr = 1;
    test_reset();
    test_fetch();
    test_cout_jr();
    test_alu_vectors();
    test_alu_random();
    test_memory();
    test_con_ba();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
